// File: rtl/uart_pkg.sv
// Shared UART definitions for the tx/rx data paths.
// State encodings, default baud divisor and frame helpers.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 5208;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: 0..BAUD_DIV-1 with synchronous clear.
// bit_end flags the last cycle of a bit, bit_near the one before it.
module uart_baud_tick #(
    parameter int BAUD_DIV = uart_pkg::DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end,
    output logic bit_near
);

    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] NEAR = 16'(BAUD_DIV - 2);

    logic [15:0] cnt;

    assign bit_end  = !clr && (cnt == LAST);
    assign bit_near = !clr && (cnt == NEAR);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/rfifo_uart_tx.sv
// Drains the SDRAM read FIFO and sends each word as a UART frame.
// Define RFIFO_UART_TX_PARITY_EN for an even parity bit (8E1).
module rfifo_uart_tx #(
    parameter int BAUD_DIV = uart_pkg::DEFAULT_BAUD_DIV,
    parameter int DATA_W   = uart_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              rfifo_empty,
    output logic              rfifo_rd_en,
    input  logic [DATA_W-1:0] rfifo_rd_data,
    output logic              rs232_tx,
    output logic              tx_busy,
    output logic              tx_done
);

    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    uart_state_t       state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    logic              bit_end;
    logic              bit_near;
    logic              baud_clr;
`ifdef RFIFO_UART_TX_PARITY_EN
    logic              parity_q;
`endif

    // Counter only runs while a bit is on the line; every serial-state
    // transition happens on bit_end, where the counter wraps to zero.
    assign baud_clr = (state == ST_IDLE) || (state == ST_FETCH) ||
                      (state == ST_LOAD);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_end  (bit_end),
        .bit_near (bit_near)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            rs232_tx    <= 1'b1;
            rfifo_rd_en <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
`ifdef RFIFO_UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            rfifo_rd_en <= 1'b0;
            tx_done     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (tx_en && !rfifo_empty) begin
                        state       <= ST_FETCH;
                        rfifo_rd_en <= 1'b1;
                        tx_busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shreg    <= rfifo_rd_data;
                    bit_cnt  <= '0;
                    rs232_tx <= 1'b0;
                    state    <= ST_START;
`ifdef RFIFO_UART_TX_PARITY_EN
                    parity_q <= even_parity(rfifo_rd_data);
`endif
                end
                ST_START: begin
                    if (bit_end) begin
                        rs232_tx <= shreg[0];
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef RFIFO_UART_TX_PARITY_EN
                            rs232_tx <= parity_q;
                            state    <= ST_PARITY;
`else
                            rs232_tx <= 1'b1;
                            state    <= ST_STOP;
`endif
                        end else begin
                            rs232_tx <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        rs232_tx <= 1'b1;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_near) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
